// File: rtl/rob_pkg.sv
// rtl/rob_pkg.sv - shared constants and types for the rob_ring reorder buffer
package rob_pkg;

  localparam int unsigned ROB_DEPTH     = 64;
  localparam int unsigned ROB_PREG_W    = 6;
  localparam int unsigned ROB_AREG_W    = 5;
  localparam int unsigned ROB_DATA_W    = 32;
  localparam int unsigned ROB_CMP_PORTS = 3;
  localparam int unsigned ROB_RET_W     = 2;
  localparam int unsigned ROB_IDX_W     = $clog2(ROB_DEPTH);

  // Index plus one wrap bit, so full and empty can be told apart
  typedef logic [ROB_IDX_W:0] rob_ptr_t;

  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic                  has_dest;
    logic [ROB_AREG_W-1:0] areg;
    logic [ROB_PREG_W-1:0] preg;
    logic [ROB_PREG_W-1:0] old_preg;
    logic [ROB_DATA_W-1:0] data;
    logic [ROB_DATA_W-1:0] pc;
  } rob_entry_t;

endpackage

// File: rtl/rob_ring_if.sv
// rtl/rob_ring_if.sv - dispatch, completion and retire bus of the reorder buffer
interface rob_ring_if
  import rob_pkg::*;
#(
  parameter int unsigned DEPTH     = ROB_DEPTH,
  parameter int unsigned PREG_W    = ROB_PREG_W,
  parameter int unsigned AREG_W    = ROB_AREG_W,
  parameter int unsigned DATA_W    = ROB_DATA_W,
  parameter int unsigned CMP_PORTS = ROB_CMP_PORTS,
  parameter int unsigned RET_W     = ROB_RET_W
);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic                        disp_valid;
  logic                        disp_ready;
  logic                        disp_has_dest;
  logic [AREG_W-1:0]           disp_areg;
  logic [PREG_W-1:0]           disp_preg;
  logic [PREG_W-1:0]           disp_old_preg;
  logic [DATA_W-1:0]           disp_pc;
  logic [IDX_W-1:0]            disp_tag;
  logic [CMP_PORTS-1:0]        cmp_valid;
  logic [CMP_PORTS*IDX_W-1:0]  cmp_tag;
  logic [CMP_PORTS*DATA_W-1:0] cmp_data;
  logic [RET_W-1:0]            ret_valid;
  logic [RET_W-1:0]            ret_has_dest;
  logic [RET_W*AREG_W-1:0]     ret_areg;
  logic [RET_W*DATA_W-1:0]     ret_data;
  logic [RET_W*PREG_W-1:0]     ret_old_preg;
  logic [RET_W*DATA_W-1:0]     ret_pc;
  logic [IDX_W:0]              count;

  modport master (
    output disp_valid, disp_has_dest, disp_areg, disp_preg, disp_old_preg, disp_pc,
    output cmp_valid, cmp_tag, cmp_data,
    input  disp_ready, disp_tag,
    input  ret_valid, ret_has_dest, ret_areg, ret_data, ret_old_preg, ret_pc, count
  );

  modport slave (
    input  disp_valid, disp_has_dest, disp_areg, disp_preg, disp_old_preg, disp_pc,
    input  cmp_valid, cmp_tag, cmp_data,
    output disp_ready, disp_tag,
    output ret_valid, ret_has_dest, ret_areg, ret_data, ret_old_preg, ret_pc, count
  );

endinterface

// File: rtl/rob_retire_select.sv
// rtl/rob_retire_select.sv - picks the in-order run of valid+done entries at head
module rob_retire_select
  import rob_pkg::*;
#(
  parameter  int unsigned DEPTH = ROB_DEPTH,
  parameter  int unsigned RET_W = ROB_RET_W,
  localparam int unsigned IDX_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(RET_W + 1)
) (
  input  logic [IDX_W-1:0] i_head,
  input  logic [DEPTH-1:0] i_valid,
  input  logic [DEPTH-1:0] i_done,
  output logic [RET_W-1:0] o_elig,
  output logic [CNT_W-1:0] o_cnt
);

  logic             w_run;
  logic [IDX_W-1:0] w_idx;

  // A slot is eligible only while no earlier slot has broken the run
  always_comb begin
    w_run  = 1'b1;
    w_idx  = '0;
    o_elig = '0;
    o_cnt  = '0;
    for (int k = 0; k < RET_W; k++) begin
      w_idx     = i_head + IDX_W'(k);
      w_run     = w_run && i_valid[w_idx] && i_done[w_idx];
      o_elig[k] = w_run;
      if (w_run) o_cnt = o_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/rob_ring.sv
// rtl/rob_ring.sv - parametrised circular reorder buffer with in-order multi-retire
// Optional synchronous flush input is enabled by defining ROB_FLUSH_EN.
module rob_ring
  import rob_pkg::*;
#(
  parameter int unsigned DEPTH     = ROB_DEPTH,
  parameter int unsigned PREG_W    = ROB_PREG_W,
  parameter int unsigned AREG_W    = ROB_AREG_W,
  parameter int unsigned DATA_W    = ROB_DATA_W,
  parameter int unsigned CMP_PORTS = ROB_CMP_PORTS,
  parameter int unsigned RET_W     = ROB_RET_W
) (
  input logic       clk,
  input logic       rstn,
`ifdef ROB_FLUSH_EN
  input logic       flush,
`endif
  rob_ring_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;
  localparam int unsigned CNT_W = $clog2(RET_W + 1);

  logic [PTR_W-1:0]        r_head, r_tail, r_count;
  logic [DEPTH-1:0]        r_valid, r_done, r_has_dest;
  logic [AREG_W-1:0]       r_areg     [DEPTH];
  logic [PREG_W-1:0]       r_preg     [DEPTH];
  logic [PREG_W-1:0]       r_old_preg [DEPTH];
  logic [DATA_W-1:0]       r_data     [DEPTH];
  logic [DATA_W-1:0]       r_pc       [DEPTH];

  logic [RET_W-1:0]        r_ret_valid, r_ret_has_dest;
  logic [RET_W*AREG_W-1:0] r_ret_areg;
  logic [RET_W*DATA_W-1:0] r_ret_data, r_ret_pc;
  logic [RET_W*PREG_W-1:0] r_ret_old_preg;

  logic                    w_full, w_disp_fire;
  logic [IDX_W-1:0]        w_tail_idx;
  logic [RET_W-1:0]        w_elig;
  logic [CNT_W-1:0]        w_ret_cnt;
  logic [IDX_W-1:0]        w_ret_idx [RET_W];
  logic [IDX_W-1:0]        w_cmp_tag [CMP_PORTS];
  logic [CMP_PORTS-1:0]    w_cmp_ok;

  assign w_tail_idx  = r_tail[IDX_W-1:0];
  assign w_full      = (r_head[IDX_W-1:0] == w_tail_idx) && (r_head[IDX_W] != r_tail[IDX_W]);
  assign w_disp_fire = bus.disp_valid && !w_full;

  assign bus.disp_ready   = !w_full;
  assign bus.disp_tag     = w_tail_idx;
  assign bus.count        = r_count;
  assign bus.ret_valid    = r_ret_valid;
  assign bus.ret_has_dest = r_ret_has_dest;
  assign bus.ret_areg     = r_ret_areg;
  assign bus.ret_data     = r_ret_data;
  assign bus.ret_old_preg = r_ret_old_preg;
  assign bus.ret_pc       = r_ret_pc;

  rob_retire_select #(
    .DEPTH (DEPTH),
    .RET_W (RET_W)
  ) u_retire_select (
    .i_head  (r_head[IDX_W-1:0]),
    .i_valid (r_valid),
    .i_done  (r_done),
    .o_elig  (w_elig),
    .o_cnt   (w_ret_cnt)
  );

  // Completions only land on live, not-yet-done entries other than the one being allocated
  always_comb begin
    w_cmp_ok = '0;
    for (int p = 0; p < CMP_PORTS; p++) begin
      w_cmp_tag[p] = bus.cmp_tag[p*IDX_W +: IDX_W];
      w_cmp_ok[p]  = bus.cmp_valid[p] && r_valid[w_cmp_tag[p]] && !r_done[w_cmp_tag[p]] &&
                     !(w_disp_fire && (w_cmp_tag[p] == w_tail_idx));
    end
    for (int k = 0; k < RET_W; k++) begin
      w_ret_idx[k] = r_head[IDX_W-1:0] + IDX_W'(k);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_valid        <= '0;
      r_done         <= '0;
      r_ret_valid    <= '0;
      r_ret_has_dest <= '0;
      r_ret_areg     <= '0;
      r_ret_data     <= '0;
      r_ret_old_preg <= '0;
      r_ret_pc       <= '0;
`ifdef ROB_FLUSH_EN
    end else if (flush) begin
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      r_valid        <= '0;
      r_done         <= '0;
      r_ret_valid    <= '0;
      r_ret_has_dest <= '0;
      r_ret_areg     <= '0;
      r_ret_data     <= '0;
      r_ret_old_preg <= '0;
      r_ret_pc       <= '0;
`endif
    end else begin
      if (w_disp_fire) begin
        r_valid[w_tail_idx] <= 1'b1;
        r_done[w_tail_idx]  <= 1'b0;
        r_tail              <= r_tail + PTR_W'(1);
      end
      for (int p = 0; p < CMP_PORTS; p++) begin
        if (w_cmp_ok[p]) r_done[w_cmp_tag[p]] <= 1'b1;
      end
      for (int k = 0; k < RET_W; k++) begin
        if (w_elig[k]) begin
          r_valid[w_ret_idx[k]] <= 1'b0;
          r_done[w_ret_idx[k]]  <= 1'b0;
        end
        r_ret_valid[k]                     <= w_elig[k];
        r_ret_has_dest[k]                  <= w_elig[k] && r_has_dest[w_ret_idx[k]];
        r_ret_areg[k*AREG_W +: AREG_W]     <= w_elig[k] ? r_areg[w_ret_idx[k]] : '0;
        r_ret_data[k*DATA_W +: DATA_W]     <= w_elig[k] ? r_data[w_ret_idx[k]] : '0;
        r_ret_old_preg[k*PREG_W +: PREG_W] <= w_elig[k] ? r_old_preg[w_ret_idx[k]] : '0;
        r_ret_pc[k*DATA_W +: DATA_W]       <= w_elig[k] ? r_pc[w_ret_idx[k]] : '0;
      end
      r_head  <= r_head + PTR_W'(w_ret_cnt);
      r_count <= r_count + PTR_W'(w_disp_fire) - PTR_W'(w_ret_cnt);
    end
  end

  // Payload storage needs no reset; the valid/done bits gate every use of it
  always_ff @(posedge clk) begin
    if (w_disp_fire) begin
      r_has_dest[w_tail_idx] <= bus.disp_has_dest;
      r_areg[w_tail_idx]     <= bus.disp_areg;
      r_preg[w_tail_idx]     <= bus.disp_preg;
      r_old_preg[w_tail_idx] <= bus.disp_old_preg;
      r_pc[w_tail_idx]       <= bus.disp_pc;
    end
    for (int p = CMP_PORTS - 1; p >= 0; p--) begin
      if (w_cmp_ok[p]) r_data[w_cmp_tag[p]] <= bus.cmp_data[p*DATA_W +: DATA_W];
    end
  end

endmodule

// File: tb/tb_rob_ring.sv
// tb/tb_rob_ring.sv - directed self-checking bench for rob_ring
module tb_rob_ring;
  import rob_pkg::*;

  localparam int DEPTH = 64;
  localparam int PREG_W = 6;
  localparam int AREG_W = 5;
  localparam int DATA_W = 32;
  localparam int CMP_PORTS = 3;
  localparam int RET_W = 2;

  logic clk = 1'b0;
  logic rstn = 1'b0;
`ifdef ROB_FLUSH_EN
  logic flush = 1'b0;
`endif
  int n_vec = 0;
  int n_err = 0;
  logic [5:0] t0, t1, t2, t3;

  always #5 clk = ~clk;

  rob_ring_if #(
    .DEPTH(DEPTH), .PREG_W(PREG_W), .AREG_W(AREG_W),
    .DATA_W(DATA_W), .CMP_PORTS(CMP_PORTS), .RET_W(RET_W)
  ) bif ();

  rob_ring #(
    .DEPTH(DEPTH), .PREG_W(PREG_W), .AREG_W(AREG_W),
    .DATA_W(DATA_W), .CMP_PORTS(CMP_PORTS), .RET_W(RET_W)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
`ifdef ROB_FLUSH_EN
    .flush(flush),
`endif
    .bus  (bif)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bif.disp_valid = 1'b0;
    bif.disp_has_dest = 1'b0;
    bif.disp_areg = '0;
    bif.disp_preg = '0;
    bif.disp_old_preg = '0;
    bif.disp_pc = '0;
    bif.cmp_valid = '0;
    bif.cmp_tag = '0;
    bif.cmp_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic disp(input logic hd, input logic [4:0] areg, input logic [5:0] oldp,
                      input logic [31:0] pc, output logic [5:0] tag);
    bif.disp_valid = 1'b1;
    bif.disp_has_dest = hd;
    bif.disp_areg = areg;
    bif.disp_preg = oldp + 6'd32;
    bif.disp_old_preg = oldp;
    bif.disp_pc = pc;
    #1;
    tag = bif.disp_tag;
    tick();
    bif.disp_valid = 1'b0;
  endtask

  task automatic cmpv(input logic [2:0] v, input logic [5:0] a, input logic [5:0] b,
                      input logic [5:0] c, input logic [31:0] da, input logic [31:0] db,
                      input logic [31:0] dc);
    bif.cmp_valid = v;
    bif.cmp_tag = {c, b, a};
    bif.cmp_data = {dc, db, da};
    tick();
    bif.cmp_valid = '0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (bif.count !== 7'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", bif.count); end
    n_vec++; if (bif.disp_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", bif.disp_ready); end
    n_vec++; if (bif.ret_valid !== 2'b00) begin n_err++; $display("FAIL reset_ret_valid: got %b expected 00", bif.ret_valid); end
    n_vec++; if (bif.disp_tag !== 6'd0) begin n_err++; $display("FAIL reset_tag: got %0d expected 0", bif.disp_tag); end
  endtask

  task automatic test_basic();
    do_reset();
    disp(1'b1, 5'd1, 6'd10, 32'h100, t0);
    disp(1'b1, 5'd2, 6'd11, 32'h104, t1);
    disp(1'b1, 5'd3, 6'd12, 32'h108, t2);
    n_vec++; if ({t0, t1, t2} !== {6'd0, 6'd1, 6'd2}) begin n_err++; $display("FAIL basic_tags: got %0d %0d %0d expected 0 1 2", t0, t1, t2); end
    n_vec++; if (bif.count !== 7'd3) begin n_err++; $display("FAIL basic_count3: got %0d expected 3", bif.count); end
    cmpv(3'b001, 6'd1, 6'd0, 6'd0, 32'h11, 0, 0);
    tick();
    n_vec++; if (bif.ret_valid !== 2'b00) begin n_err++; $display("FAIL basic_gap: got %b expected 00", bif.ret_valid); end
    cmpv(3'b001, 6'd0, 6'd0, 6'd0, 32'h10, 0, 0);
    n_vec++; if (bif.ret_valid !== 2'b00) begin n_err++; $display("FAIL basic_latency: got %b expected 00", bif.ret_valid); end
    tick();
    n_vec++; if (bif.ret_valid !== 2'b11) begin n_err++; $display("FAIL basic_ret_valid: got %b expected 11", bif.ret_valid); end
    n_vec++; if (bif.ret_pc !== {32'h104, 32'h100}) begin n_err++; $display("FAIL basic_ret_pc: got %h expected %h", bif.ret_pc, {32'h104, 32'h100}); end
    n_vec++; if (bif.ret_data !== {32'h11, 32'h10}) begin n_err++; $display("FAIL basic_ret_data: got %h expected %h", bif.ret_data, {32'h11, 32'h10}); end
    n_vec++; if (bif.ret_old_preg !== {6'd11, 6'd10}) begin n_err++; $display("FAIL basic_old_preg: got %h expected %h", bif.ret_old_preg, {6'd11, 6'd10}); end
    n_vec++; if (bif.ret_areg !== {5'd2, 5'd1}) begin n_err++; $display("FAIL basic_areg: got %h expected %h", bif.ret_areg, {5'd2, 5'd1}); end
    n_vec++; if (bif.count !== 7'd1) begin n_err++; $display("FAIL basic_count1: got %0d expected 1", bif.count); end
    cmpv(3'b001, 6'd2, 6'd0, 6'd0, 32'h12, 0, 0);
    tick();
    n_vec++; if (bif.ret_valid !== 2'b01 || bif.ret_pc[31:0] !== 32'h108) begin n_err++; $display("FAIL basic_last: got %b/%h expected 01/108", bif.ret_valid, bif.ret_pc[31:0]); end
    tick();
    n_vec++; if (bif.ret_valid !== 2'b00 || bif.count !== 7'd0) begin n_err++; $display("FAIL basic_idle: got %b/%0d expected 00/0", bif.ret_valid, bif.count); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 64; i++) disp(1'b1, 5'd0, 6'(i), 32'(i * 4), t0);
    n_vec++; if (bif.disp_ready !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b expected 0", bif.disp_ready); end
    n_vec++; if (bif.count !== 7'd64) begin n_err++; $display("FAIL full_count: got %0d expected 64", bif.count); end
    bif.disp_valid = 1'b1;
    bif.disp_pc = 32'hDEAD;
    tick();
    bif.disp_valid = 1'b0;
    n_vec++; if (bif.count !== 7'd64) begin n_err++; $display("FAIL full_reject: got %0d expected 64", bif.count); end
    cmpv(3'b001, 6'd0, 6'd0, 6'd0, 32'hF0, 0, 0);
    n_vec++; if (bif.disp_ready !== 1'b0) begin n_err++; $display("FAIL full_still: got %b expected 0", bif.disp_ready); end
    tick();
    n_vec++; if (bif.disp_ready !== 1'b1 || bif.ret_valid !== 2'b01) begin n_err++; $display("FAIL full_freed: got %b/%b expected 1/01", bif.disp_ready, bif.ret_valid); end
    n_vec++; if (bif.count !== 7'd63) begin n_err++; $display("FAIL full_count63: got %0d expected 63", bif.count); end
    disp(1'b1, 5'd0, 6'd0, 32'h1000, t0);
    n_vec++; if (t0 !== 6'd0 || bif.disp_ready !== 1'b0) begin n_err++; $display("FAIL full_refill: got %0d/%b expected 0/0", t0, bif.disp_ready); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 62; i++) disp(1'b1, 5'd0, 6'd0, 32'(i), t0);
    for (int i = 0; i < 62; i++) cmpv(3'b001, 6'(i), 6'd0, 6'd0, 32'(i), 0, 0);
    repeat (3) tick();
    n_vec++; if (bif.count !== 7'd0 || bif.disp_tag !== 6'd62) begin n_err++; $display("FAIL wrap_setup: got %0d/%0d expected 0/62", bif.count, bif.disp_tag); end
    disp(1'b1, 5'd1, 6'd1, 32'h200, t0);
    disp(1'b1, 5'd2, 6'd2, 32'h204, t1);
    disp(1'b1, 5'd3, 6'd3, 32'h208, t2);
    disp(1'b1, 5'd4, 6'd4, 32'h20C, t3);
    n_vec++; if ({t0, t1, t2, t3} !== {6'd62, 6'd63, 6'd0, 6'd1}) begin n_err++; $display("FAIL wrap_tags: got %0d %0d %0d %0d expected 62 63 0 1", t0, t1, t2, t3); end
    cmpv(3'b111, 6'd62, 6'd63, 6'd0, 1, 2, 3);
    cmpv(3'b001, 6'd1, 6'd0, 6'd0, 4, 0, 0);
    n_vec++; if (bif.ret_valid !== 2'b11 || bif.ret_pc !== {32'h204, 32'h200}) begin n_err++; $display("FAIL wrap_grp1: got %b/%h expected 11/%h", bif.ret_valid, bif.ret_pc, {32'h204, 32'h200}); end
    tick();
    n_vec++; if (bif.ret_valid !== 2'b11 || bif.ret_pc !== {32'h20C, 32'h208}) begin n_err++; $display("FAIL wrap_grp2: got %b/%h expected 11/%h", bif.ret_valid, bif.ret_pc, {32'h20C, 32'h208}); end
    tick();
    n_vec++; if (bif.count !== 7'd0) begin n_err++; $display("FAIL wrap_drain: got %0d expected 0", bif.count); end
  endtask

  task automatic test_port_priority();
    for (int i = 0; i < 4; i++) disp(1'b1, 5'd0, 6'd0, 32'h300 + 32'(i * 4), t0);
    cmpv(3'b111, 6'd2, 6'd3, 6'd4, 2, 3, 4);
    cmpv(3'b111, 6'd5, 6'd5, 6'd9, 32'hAA, 32'hBB, 32'hCC);
    tick();
    n_vec++; if (bif.ret_valid !== 2'b11 || bif.ret_data[63:32] !== 32'hAA) begin n_err++; $display("FAIL prio_data: got %b/%h expected 11/aa", bif.ret_valid, bif.ret_data[63:32]); end
    n_vec++; if (bif.ret_pc[63:32] !== 32'h30C) begin n_err++; $display("FAIL prio_pc: got %h expected 30c", bif.ret_pc[63:32]); end
    for (int i = 0; i < 4; i++) disp(1'b1, 5'd0, 6'd0, 32'h310 + 32'(i * 4), t0);
    n_vec++; if (t0 !== 6'd9) begin n_err++; $display("FAIL prio_tag9: got %0d expected 9", t0); end
    cmpv(3'b111, 6'd6, 6'd7, 6'd8, 6, 7, 8);
    repeat (3) tick();
    n_vec++; if (bif.count !== 7'd1 || bif.ret_valid !== 2'b00) begin n_err++; $display("FAIL prio_stray: got %0d/%b expected 1/00", bif.count, bif.ret_valid); end
    cmpv(3'b001, 6'd9, 6'd0, 6'd0, 32'hDD, 0, 0);
    tick();
    n_vec++; if (bif.ret_valid !== 2'b01 || bif.ret_data[31:0] !== 32'hDD) begin n_err++; $display("FAIL prio_late: got %b/%h expected 01/dd", bif.ret_valid, bif.ret_data[31:0]); end
  endtask

  task automatic test_no_dest();
    disp(1'b1, 5'd3, 6'd20, 32'h400, t0);
    disp(1'b0, 5'd0, 6'd21, 32'h404, t1);
    disp(1'b1, 5'd7, 6'd22, 32'h408, t2);
    cmpv(3'b111, t0, t1, t2, 1, 2, 3);
    tick();
    n_vec++; if (bif.ret_valid !== 2'b11 || bif.ret_has_dest !== 2'b01) begin n_err++; $display("FAIL nodest_grp1: got %b/%b expected 11/01", bif.ret_valid, bif.ret_has_dest); end
    n_vec++; if (bif.ret_pc !== {32'h404, 32'h400}) begin n_err++; $display("FAIL nodest_pc: got %h expected %h", bif.ret_pc, {32'h404, 32'h400}); end
    tick();
    n_vec++; if (bif.ret_valid !== 2'b01 || bif.ret_has_dest !== 2'b01 || bif.ret_areg[4:0] !== 5'd7) begin n_err++; $display("FAIL nodest_grp2: got %b/%b/%0d expected 01/01/7", bif.ret_valid, bif.ret_has_dest, bif.ret_areg[4:0]); end
  endtask

  task automatic test_reset_mid();
    disp(1'b1, 5'd1, 6'd1, 32'h500, t0);
    disp(1'b1, 5'd2, 6'd2, 32'h504, t1);
    cmpv(3'b011, t0, t1, 6'd0, 5, 6, 0);
    tick();
    n_vec++; if (bif.ret_valid !== 2'b11) begin n_err++; $display("FAIL rstmid_pre: got %b expected 11", bif.ret_valid); end
    rstn = 1'b0;
    #1;
    n_vec++; if (bif.ret_valid !== 2'b00 || bif.ret_pc !== 64'd0 || bif.ret_data !== 64'd0) begin n_err++; $display("FAIL rstmid_ret: got %b/%h/%h expected zeros", bif.ret_valid, bif.ret_pc, bif.ret_data); end
    n_vec++; if (bif.count !== 7'd0 || bif.disp_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_state: got %0d/%b expected 0/1", bif.count, bif.disp_ready); end
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

`ifdef ROB_FLUSH_EN
  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 10; i++) disp(1'b1, 5'd0, 6'd0, 32'h600 + 32'(i), t0);
    cmpv(3'b011, 6'd0, 6'd1, 6'd0, 1, 2, 0);
    flush = 1'b1;
    bif.disp_valid = 1'b1;
    tick();
    flush = 1'b0;
    bif.disp_valid = 1'b0;
    n_vec++; if (bif.count !== 7'd0 || bif.ret_valid !== 2'b00) begin n_err++; $display("FAIL flush_state: got %0d/%b expected 0/00", bif.count, bif.ret_valid); end
    disp(1'b1, 5'd0, 6'd0, 32'h700, t0);
    n_vec++; if (t0 !== 6'd0) begin n_err++; $display("FAIL flush_tag: got %0d expected 0", t0); end
    repeat (2) tick();
    n_vec++; if (bif.ret_valid !== 2'b00 || bif.count !== 7'd1) begin n_err++; $display("FAIL flush_after: got %b/%0d expected 00/1", bif.ret_valid, bif.count); end
  endtask
`endif

  initial begin
    idle_inputs();
    test_reset();
    test_basic();
    test_full();
    test_wrap();
    test_port_priority();
    test_no_dest();
    test_reset_mid();
`ifdef ROB_FLUSH_EN
    test_flush();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
